// File: rtl/pc_fetch_if.sv
// Fetch-stage bus bundle: ROM request/response channel and the instruction
// delivery channel toward decode/execute.
interface pc_fetch_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The sender keeps valid and its payload stable until that transfer; ready
  // may change freely and never waits on valid. rom_rsp has no back-pressure.
  logic              rom_req_valid;
  logic              rom_req_ready;
  logic [ADDR_W-1:0] rom_req_addr;
  logic              rom_rsp_valid;
  logic [DATA_W-1:0] rom_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output rom_req_valid, rom_req_addr, instr_valid, instr_data, instr_pc,
    input  rom_req_ready, rom_rsp_valid, rom_rsp_data, instr_ready
  );

  modport slave (
    input  rom_req_valid, rom_req_addr, instr_valid, instr_data, instr_pc,
    output rom_req_ready, rom_rsp_valid, rom_rsp_data, instr_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and prefetch stage: issues in-order ROM reads under a
// credit limit, tags responses with their PC and queues them for decode.
module pc_fetch #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jmp_load,
  input  logic [ADDR_W-1:0] jmp_addr,
  pc_fetch_if.master        bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  q_wr, q_rd, tag_wr, tag_rd;
  logic [CNT_W-1:0]  q_cnt, out_cnt, drop_cnt;
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] tag_pc [DEPTH];

  logic              q_nonempty, pop, accept, rsp, keep;
  logic [CNT_W:0]    in_use;
  logic [CNT_W-1:0]  out_next;

  always_comb begin
    q_nonempty = (q_cnt != '0);
    pop        = q_nonempty && bus.instr_ready;
    // Queued words plus in-flight reads form the credit pool; a slot freed by
    // this cycle's pop may be spent immediately.
    in_use     = (CNT_W + 1)'(q_cnt) + (CNT_W + 1)'(out_cnt) - (CNT_W + 1)'(pop);
    bus.rom_req_valid = rst_n && (in_use < DEPTH_C);
    bus.rom_req_addr  = fetch_pc;
    accept     = bus.rom_req_valid && bus.rom_req_ready;
    rsp        = bus.rom_rsp_valid;
    keep       = rsp && (drop_cnt == '0) && !jmp_load;
    out_next   = out_cnt + CNT_W'(accept) - CNT_W'(rsp);
    bus.instr_valid = q_nonempty;
    bus.instr_data  = q_nonempty ? q_data[q_rd] : '0;
    bus.instr_pc    = q_nonempty ? q_pc[q_rd]   : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      q_cnt    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (jmp_load)    fetch_pc <= jmp_addr;
      else if (accept) fetch_pc <= fetch_pc + ADDR_W'(1);

      out_cnt <= out_next;
      if (accept) tag_wr <= tag_wr + PTR_W'(1);
      if (rsp)    tag_rd <= tag_rd + PTR_W'(1);

      // Everything still in flight after this cycle, including a read accepted
      // right now, belongs to the abandoned path.
      if (jmp_load)                     drop_cnt <= out_next;
      else if (rsp && drop_cnt != '0)   drop_cnt <= drop_cnt - CNT_W'(1);

      if (jmp_load) begin
        q_wr  <= '0;
        q_rd  <= '0;
        q_cnt <= '0;
      end else begin
        if (keep) q_wr <= q_wr + PTR_W'(1);
        if (pop)  q_rd <= q_rd + PTR_W'(1);
        q_cnt <= q_cnt + CNT_W'(keep) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset: contents are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (accept) tag_pc[tag_wr] <= fetch_pc;
    if (keep) begin
      q_pc[q_wr]   <= tag_pc[tag_rd];
      q_data[q_wr] <= bus.rom_rsp_data;
    end
  end
endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program counter and instruction fetch stage for the Hack-style CPU core. It sits directly downstream of the jump decision logic: it consumes the jump-taken strobe and target address and otherwise advances sequentially. It issues in-order read requests to instruction ROM and buffers the returned words in a small prefetch queue. The queue delivers each instruction, with its PC, to the decode/execute stage over a valid/ready handshake.

## Interface
- ADDR_W, 15, instruction address width (32K-word ROM)
- DATA_W, 16, instruction word width
- DEPTH, 4, prefetch queue entries; also the cap on queued plus in-flight fetches (power of two, ≥2)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- jmp_load  in  1  jump taken this cycle (registered jump decision, already gated by C-instruction opcode)
- jmp_addr  in  ADDR_W  jump target (A register), sampled when jmp_load=1
- rom_req_valid  out  1  fetch request valid
- rom_req_ready  in  1  ROM accepts request
- rom_req_addr  out  ADDR_W  fetch address
- rom_rsp_valid  in  1  read data valid (in request order, latency ≥1)
- rom_rsp_data  in  DATA_W  read data
- instr_valid  out  1  head of queue valid
- instr_ready  in  1  downstream consumes head
- instr_data  out  DATA_W  instruction word
- instr_pc  out  ADDR_W  address the word was fetched from

## Operation
- State: fetch_pc, queue of {pc, data}, outstanding count, drop count.
- Request issue rule:
  - rom_req_valid=1 iff occupancy + outstanding − (pop this cycle) < DEPTH.
  - rom_req_addr=fetch_pc.
- Request accept: on rom_req_valid && rom_req_ready, fetch_pc increments and wraps 2^ADDR_W−1 → 0. Outstanding increments.
- Response: on rom_rsp_valid, outstanding decrements.
  - If drop count > 0, the word is discarded and drop count decrements.
  - Otherwise the word is written to the queue tail, tagged with its request PC.
  - Per-request PCs are tracked in a DEPTH-entry tag FIFO.
- Pop: on instr_valid && instr_ready, the head is removed.
- Redirect (jmp_load=1):
  - fetch_pc ← jmp_addr.
  - The queue is flushed.
  - Drop count ← outstanding after this cycle's accept/response updates, so every in-flight request, including one accepted this cycle, is discarded on return.
- rom_req_valid may deassert, and rom_req_addr may change, only on a redirect or after acceptance. Otherwise the request holds stable until rom_req_ready.
- Simultaneous events:
  - jmp_load with pop: the pop completes, then the flush applies.
  - jmp_load with rom_rsp_valid: the response is discarded.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
- Flush with drop count nonzero: new requests are still issued, bounded by the credit rule. New responses are kept only after drop count reaches 0.
- The queue never overflows. A response arriving with the queue full is impossible by the credit rule; the bench asserts this.

## Timing
- Reset values:
  - rom_req_valid=0, rom_req_addr=0, instr_valid=0, instr_data=0, instr_pc=0.
  - fetch_pc=0, occupancy=0, outstanding=0, drop=0.
- First cycle after rst_n rises: rom_req_valid=1, rom_req_addr=0.
- instr_valid is registered from queue non-empty. Latency from ROM response to instr_valid is 1 cycle.
- With a 1-cycle ROM (rsp the cycle after accept) and rom_req_ready=1:
  - Request at cycle T → instr_valid at T+2.
  - Sustained throughput is 1 instruction/cycle with instr_ready=1.
- Redirect at cycle N → rom_req_addr=jmp_addr at N+1. With a 1-cycle ROM, instr_pc=jmp_addr and instr_valid at N+3.
- Reset mid-operation clears all state immediately. In-flight ROM responses after reset are the environment's responsibility: ROM is reset together with this block.

## Test plan
- Reset release, 1-cycle ROM returning data=addr^16'hA5A5, instr_ready=1 → instr_pc sequence 0,1,2,3… from cycle 2, one per cycle, instr_data matching, no gaps.
- instr_ready=0 from reset → exactly 4 requests (addr 0–3), rom_req_valid low thereafter, occupancy 4. Then instr_ready=1 → PCs 0,1,2,3,4 back-to-back.
- Stream running, jmp_load=1 with jmp_addr=0x0100 while 2 requests are in flight → neither stale word is presented. The next instr_pc is 0x0100, then 0x0101.
- jmp_addr=0x7FFE, run 4 instructions → instr_pc 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- rom_req_ready toggled randomly (50%), 3-cycle ROM latency → PCs strictly sequential, rom_req_addr stable while valid && !ready, outstanding never exceeds 4.
- rst_n pulsed low mid-stream with a full queue → all outputs at reset values during reset. After release, fetch restarts at PC 0.
